// File: rtl/bp_pkg.sv
// Types and constants shared by the local branch predictor and its
// resolution queue.
package bp_pkg;

  localparam int PC_W = 10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } bp_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } brq_state_t;

endpackage

// File: rtl/brq_fifo.sv
// Circular buffer of in-flight branch entries in program order.
// The pointers carry an extra wrap bit so that full and empty are exact.
module brq_fifo #(
  parameter  int W     = 11,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_head;
  logic [AW:0]  r_tail;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty = (r_head == r_tail);
  assign o_full  = (r_head[AW] != r_tail[AW]) &&
                   (r_head[AW-1:0] == r_tail[AW-1:0]);
  assign o_count = r_tail - r_head;
  assign o_rdata = r_mem[r_head[AW-1:0]];

  // A clear drops every entry, so a push offered alongside it is ignored.
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (i_clear)       r_head <= r_tail;
      else if (w_do_pop) r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_tail[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Resolution-side queue: holds issued predictions, resolves them in order,
// drives predictor training, squashes wrong-path entries on a mispredict.
module branch_resolve_queue #(
  parameter  int PC_W  = bp_pkg::PC_W,
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             res_ready,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             upd_mispredict,
  output logic             flush,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  import bp_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  brq_state_t       r_state;
  brq_state_t       w_state_nxt;
  logic             w_full;
  logic             w_empty;
  logic [PC_W:0]    w_rd_entry;
  logic [PC_W-1:0]  w_rd_pc;
  logic             w_rd_taken;
  logic             w_push;
  logic             w_pop;
  logic             w_mis;

  assign w_rd_pc    = w_rd_entry[PC_W:1];
  assign w_rd_taken = w_rd_entry[0];

  assign pred_ready = (r_state == RUN) && !w_full;
  assign res_ready  = !w_empty;

  assign w_pop  = res_valid && res_ready;
  assign w_mis  = w_pop && (w_rd_taken != res_taken);
  // A push in the mispredict cycle is on the wrong path and is dropped.
  assign w_push = pred_valid && pred_ready && !w_mis;

  brq_fifo #(
    .W     (PC_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({pred_pc, pred_taken}),
    .i_pop   (w_pop),
    .i_clear (w_mis),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  always_ff @(posedge clock) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_mis) w_state_nxt = RECOVER;
      RECOVER: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Training outputs: pulse valid/flush, hold the data fields between pops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_mispredict <= 1'b0;
      flush          <= 1'b0;
    end else begin
      upd_valid <= w_pop;
      flush     <= w_mis;
      if (w_pop) begin
        upd_pc         <= w_rd_pc;
        upd_taken      <= res_taken;
        upd_mispredict <= w_mis;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (w_pop) branch_count     <= sat_inc(branch_count);
      if (w_mis) mispredict_count <= sat_inc(mispredict_count);
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a
// queue-based reference model; a second instance uses 4-bit counters.
module tb_branch_resolve_queue;
  localparam int PC_W  = 10;
  localparam int DEPTH = 8;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic clock = 1'b0;
  logic reset;
  logic pred_valid, pred_taken, res_valid, res_taken;
  logic [PC_W-1:0] pred_pc;

  logic             a_pred_ready, a_res_ready, a_upd_valid, a_upd_taken, a_upd_mis, a_flush;
  logic [PC_W-1:0]  a_upd_pc;
  logic [OCC_W-1:0] a_occ;
  logic [15:0]      a_bc, a_mc;

  logic             b_pred_ready, b_res_ready, b_upd_valid, b_upd_taken, b_upd_mis, b_flush;
  logic [PC_W-1:0]  b_upd_pc;
  logic [OCC_W-1:0] b_occ;
  logic [3:0]       b_bc, b_mc;

  always #5 clock = ~clock;

  branch_resolve_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(a_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(a_res_ready),
    .upd_valid(a_upd_valid), .upd_pc(a_upd_pc), .upd_taken(a_upd_taken),
    .upd_mispredict(a_upd_mis), .flush(a_flush), .occupancy(a_occ),
    .branch_count(a_bc), .mispredict_count(a_mc)
  );

  branch_resolve_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(b_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(b_res_ready),
    .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_taken(b_upd_taken),
    .upd_mispredict(b_upd_mis), .flush(b_flush), .occupancy(b_occ),
    .branch_count(b_bc), .mispredict_count(b_mc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: in-flight branches as {pc, predicted}, oldest first.
  logic [PC_W:0]   m_q[$];
  bit              m_rec;
  bit              m_uv, m_ut, m_um, m_fl;
  logic [PC_W-1:0] m_upc;
  int              m_bc, m_mc;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all();
    expect_eq("occupancy", 32'(a_occ), m_q.size());
    expect_eq("pred_ready", 32'(a_pred_ready), 32'(!m_rec && m_q.size() < DEPTH));
    expect_eq("res_ready", 32'(a_res_ready), 32'(m_q.size() != 0));
    expect_eq("upd_valid", 32'(a_upd_valid), 32'(m_uv));
    expect_eq("upd_pc", 32'(a_upd_pc), 32'(m_upc));
    expect_eq("upd_taken", 32'(a_upd_taken), 32'(m_ut));
    expect_eq("upd_mispredict", 32'(a_upd_mis), 32'(m_um));
    expect_eq("flush", 32'(a_flush), 32'(m_fl));
    expect_eq("branch_count", 32'(a_bc), sat(m_bc, 65535));
    expect_eq("mispredict_count", 32'(a_mc), sat(m_mc, 65535));
    expect_eq("branch_count_w4", 32'(b_bc), sat(m_bc, 15));
    expect_eq("mispredict_count_w4", 32'(b_mc), sat(m_mc, 15));
    expect_eq("upd_valid_w4", 32'(b_upd_valid), 32'(m_uv));
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model,
  // then compare at the next falling edge.
  task automatic step(input logic rst_n, input logic pv, input logic [PC_W-1:0] ppc,
                      input logic pt, input logic rv, input logic rt);
    bit pr, rr, mis;
    logic [PC_W:0] e;
    reset = rst_n; pred_valid = pv; pred_pc = ppc; pred_taken = pt;
    res_valid = rv; res_taken = rt;
    mis = 1'b0;
    if (!rst_n) begin
      m_q.delete(); m_rec = 0; m_uv = 0; m_upc = '0; m_ut = 0; m_um = 0; m_fl = 0;
      m_bc = 0; m_mc = 0;
    end else begin
      pr = !m_rec && (m_q.size() < DEPTH);
      rr = (m_q.size() != 0);
      m_uv = 0; m_fl = 0;
      if (rv && rr) begin
        e = m_q.pop_front();
        mis = (e[0] != rt);
        m_uv = 1; m_upc = e[PC_W:1]; m_ut = rt; m_um = mis; m_bc++;
        if (mis) begin
          m_mc++; m_fl = 1; m_q.delete();
        end
      end
      m_rec = mis;
      if (pv && pr && !mis) m_q.push_back({ppc, pt});
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic idle();
    step(1, 0, '0, 0, 0, 0);
  endtask

  initial begin
    int pcs[3];
    logic rt;
    reset = 0; pred_valid = 0; pred_pc = '0; pred_taken = 0; res_valid = 0; res_taken = 0;
    @(negedge clock);
    step(0, 0, '0, 0, 0, 0);
    step(0, 1, 10'd5, 1, 1, 1);
    expect_eq("rst_occ", 32'(a_occ), 0);
    idle();
    expect_eq("rst_pred_ready", 32'(a_pred_ready), 1);
    expect_eq("rst_res_ready", 32'(a_res_ready), 0);

    // In-order correct resolution
    pcs = '{30, 10, 20};
    foreach (pcs[i]) step(1, 1, PC_W'(pcs[i]), 1, 0, 0);
    foreach (pcs[i]) begin
      step(1, 0, '0, 0, 1, 1);
      expect_eq("inorder_pc", 32'(a_upd_pc), pcs[i]);
      expect_eq("inorder_mis", 32'(a_upd_mis), 0);
    end
    expect_eq("inorder_bc", 32'(a_bc), 3);
    expect_eq("inorder_mc", 32'(a_mc), 0);

    // Full queue rejects a push even with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) step(1, 1, PC_W'(100 + i), 1, 0, 0);
    expect_eq("full_occ", 32'(a_occ), DEPTH);
    expect_eq("full_pred_ready", 32'(a_pred_ready), 0);
    step(1, 1, 10'd200, 1, 1, 1);
    expect_eq("full_pushpop_occ", 32'(a_occ), DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) step(1, 0, '0, 0, 1, 1);
    expect_eq("drain_last_pc", 32'(a_upd_pc), 107);

    // Mispredict squashes younger entries and the same-cycle push
    step(1, 1, 10'd10, 1, 0, 0);
    step(1, 1, 10'd20, 1, 0, 0);
    step(1, 1, 10'd30, 1, 0, 0);
    step(1, 1, 10'd99, 1, 1, 0);
    expect_eq("mis_pc", 32'(a_upd_pc), 10);
    expect_eq("mis_flag", 32'(a_upd_mis), 1);
    expect_eq("mis_flush", 32'(a_flush), 1);
    expect_eq("mis_occ", 32'(a_occ), 0);
    expect_eq("mis_pred_ready", 32'(a_pred_ready), 0);
    idle();
    expect_eq("recover_done_ready", 32'(a_pred_ready), 1);
    expect_eq("recover_flush_clear", 32'(a_flush), 0);

    // Resolve on an empty queue, then steady push/pop across the wrap
    step(1, 0, '0, 0, 1, 1);
    expect_eq("empty_res_upd", 32'(a_upd_valid), 0);
    step(1, 1, 10'd300, 1, 0, 0);
    for (int i = 1; i <= 20; i++) step(1, 1, PC_W'(300 + i), i[0], 1, !i[0]);
    expect_eq("stream_occ", 32'(a_occ), 1);
    step(1, 0, '0, 0, 1, 0);

    // Saturate the 4-bit counters with repeated mispredicts
    for (int i = 0; i < 20; i++) begin
      step(1, 1, PC_W'(400 + i), 1, 0, 0);
      step(1, 0, '0, 0, 1, 0);
      idle();
    end
    expect_eq("sat_bc_w4", 32'(b_bc), 15);
    expect_eq("sat_mc_w4", 32'(b_mc), 15);

    // Reset with entries in flight
    for (int i = 0; i < 5; i++) step(1, 1, PC_W'(500 + i), 1, 0, 0);
    step(0, 0, '0, 0, 1, 1);
    expect_eq("midrst_occ", 32'(a_occ), 0);
    expect_eq("midrst_upd", 32'(a_upd_valid), 0);
    expect_eq("midrst_bc", 32'(a_bc), 0);
    idle();
    expect_eq("midrst_upd_after", 32'(a_upd_valid), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_q.size() != 0 && $urandom_range(0, 99) < 80) rt = m_q[0][0];
      else rt = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
           PC_W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
